alu_issue_ctrl: RTL and testbench
=================================

// Module: alu_issue_ctrl
// PURPOSE
//  Multi-cycle execute controller that drives the KGP-RISC ALU from the initiator side.
//  - Accepts one 32-bit instruction through a valid/ready handshake.
//  - Decodes it into a 4-bit ALU mode, reads the register file and presents operands with alu_en.
//  - Captures the ALU result, writes it back and publishes zero/sign flags for branch logic.
//  - Sits between the fetch stage and the ALU/register file.
// PARAMETERS
//  DATA_W   32  datapath width; must equal the ALU operand width
//  REG_AW   5   register address width (32 registers)
//  R0_ZERO  1   1: writes to r0 are suppressed (r0 hardwired to zero)
// PORTS
//  clk        in   1       rising-edge clock
//  rst        in   1       synchronous reset, active-high
//  in_valid   in   1       instr is valid
//  in_ready   out  1       controller can accept instr (high only in IDLE)
//  instr      in   32      [31:26] opcode, [25:21] rs, [20:16] rt, [15:11] rd, [3:0] funct, [15:0] imm
//  rf_raddr1  out  REG_AW  read address port 1 (rs); register file read is combinational
//  rf_raddr2  out  REG_AW  read address port 2 (rt)
//  rf_rdata1  in   DATA_W  data for rf_raddr1
//  rf_rdata2  in   DATA_W  data for rf_raddr2
//  alu_op1    out  DATA_W  ALU operand1
//  alu_op2    out  DATA_W  ALU operand2
//  alu_mode   out  4       ALU mode
//  alu_en     out  1       ALU enable
//  alu_out    in   DATA_W  ALU result
//  rf_we      out  1       one-cycle write-enable pulse
//  rf_waddr   out  REG_AW  write address
//  rf_wdata   out  DATA_W  write data
//  zero_flag  out  1       last result == 0; held until the next WB
//  sign_flag  out  1       last result[DATA_W-1]; held until the next WB
//  illegal    out  1       one-cycle pulse on an undecodable instruction
// BEHAVIOUR
//  Reset: every output is 0 except in_ready = 1; state = IDLE.
//  States: IDLE -> DECODE -> EXEC -> WB -> IDLE.
//  - IDLE: in_ready = 1. When in_valid = 1, instr is latched and the FSM moves to DECODE. No other state accepts instr.
//  - DECODE:
//    - Drive rf_raddr1 = rs and rf_raddr2 = rt. Capture rf_rdata1, rf_rdata2 and the decoded mode/dest.
//    - Illegal instruction: pulse illegal for 1 cycle, go to IDLE, no write.
//  - EXEC: alu_en = 1 with the registered op1, op2 and mode. alu_out is captured at the end of the cycle.
//  - WB:
//    - rf_we = 1 (0 if R0_ZERO and dest == 0), rf_wdata = captured result.
//    - zero_flag and sign_flag update at the end of the cycle.
//  - alu_en = 0 and alu_op1, alu_op2, alu_mode are held in every state except EXEC.
//  Latency: handshake at cycle N; rf_we is high at cycle N+3. Next in_ready is at N+4 (1 instruction per 4 cycles).
//  Decode:
//  - Opcode 6'h00 (R-type): mode = funct, op1 = rs, op2 = rt, dest = rd.
//    - funct 0..9 is legal; funct 10..15 is illegal.
//  - I-type: op1 = rs, op2 = sext(imm16), dest = rt.
//    - 6'h01 ADDI: mode 0
//    - 6'h02 ANDI: mode 2
//    - 6'h03 ORI: mode 3
//    - 6'h04 XORI: mode 4
//    - 6'h05 LEA: mode 10; the ALU computes rs + (imm << 2)
//  - Any other opcode is illegal.
//  - Shift modes pass the full rt value as the shift amount; no masking.
//  - NOT (mode 5) ignores op2 but still reads rt.
//  Boundaries:
//  - Reset in any state returns to IDLE the next cycle. An in-flight rf_we is never issued, and illegal is not pulsed.
//  - in_valid held high across instructions: a new instr is taken only in IDLE. Back-to-back accepts are 4 cycles apart.
//  - Wrap-around: arithmetic is modulo 2^DATA_W. The ALU carry is not exported.
// STRUCTURE
//  - Package kgp_isa_pkg:
//    - opcode localparams (OP_RTYPE, OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_LEA)
//    - ALU mode constants (ALU_ADD .. ALU_ADDSH2)
//    - FSM state encoding (IDLE, DECODE, EXEC, WB)
//  - Sub-module alu_ctrl_decode: combinational instr -> {mode, dest, use_imm, illegal}.
//  - FSM and registers stay in this module.
// TESTING
//  1. After reset, check in_ready = 1 and all other outputs = 0. R-type ADD with r1 = 5, r2 = 7, rd = r3:
//     rf_we at N+3 with waddr 3, wdata 12, zero_flag = 0.
//  2. SUB with r1 = r2 = 0x80000000 -> wdata 0, zero_flag = 1, sign_flag = 0.
//     SUB with r1 = 0, r2 = 1 -> wdata 0xFFFFFFFF, sign_flag = 1.
//  3. Immediates, each written to rt:
//     - ADDI r4 = r0 + 0xFFFF -> 0xFFFFFFFF
//     - LEA with rs = 0x1000, imm 4 -> 0x1010
//  4. Illegal opcode 6'h3F or funct 4'hB -> illegal pulse at N+1, no rf_we, in_ready = 1 at N+2.
//  5. R-type with rd = 0 and R0_ZERO = 1 -> rf_we stays 0; flags still update.
//  6. in_valid held high with 3 queued instrs -> accepts at N, N+4, N+8.
//     Assert rst at an EXEC cycle -> no rf_we, IDLE next cycle.

Source files
------------

// File: rtl/kgp_isa_pkg.sv
// KGP-RISC ISA constants shared by the ALU issue controller and its decoder.
// Opcodes, ALU mode encodings and the issue FSM state type.
package kgp_isa_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h01;
  localparam logic [5:0] OP_ANDI  = 6'h02;
  localparam logic [5:0] OP_ORI   = 6'h03;
  localparam logic [5:0] OP_XORI  = 6'h04;
  localparam logic [5:0] OP_LEA   = 6'h05;

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_AND    = 4'd2;
  localparam logic [3:0] ALU_OR     = 4'd3;
  localparam logic [3:0] ALU_XOR    = 4'd4;
  localparam logic [3:0] ALU_NOT    = 4'd5;
  localparam logic [3:0] ALU_SLL    = 4'd6;
  localparam logic [3:0] ALU_SRL    = 4'd7;
  localparam logic [3:0] ALU_SRA    = 4'd8;
  localparam logic [3:0] ALU_SLA    = 4'd9;
  localparam logic [3:0] ALU_ADDSH2 = 4'd10;

  // Highest funct value an R-type instruction may carry.
  localparam logic [3:0] ALU_RTYPE_MAX = ALU_SLA;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    WB     = 2'd3
  } state_e;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational instruction decoder for the ALU issue controller.
// Maps opcode/funct to ALU mode, destination register and operand source.
module alu_ctrl_decode
  import kgp_isa_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [3:0] funct_i,
  input  logic [4:0] rt_i,
  input  logic [4:0] rd_i,
  output logic [3:0] mode_o,
  output logic [4:0] dest_o,
  output logic       use_imm_o,
  output logic       illegal_o
);

  always_comb begin
    mode_o    = ALU_ADD;
    dest_o    = rt_i;
    use_imm_o = 1'b1;
    illegal_o = 1'b0;
    unique case (1'b1)
      (opcode_i == OP_RTYPE): begin
        mode_o    = funct_i;
        dest_o    = rd_i;
        use_imm_o = 1'b0;
        illegal_o = (funct_i > ALU_RTYPE_MAX);
      end
      (opcode_i == OP_ADDI): mode_o = ALU_ADD;
      (opcode_i == OP_ANDI): mode_o = ALU_AND;
      (opcode_i == OP_ORI):  mode_o = ALU_OR;
      (opcode_i == OP_XORI): mode_o = ALU_XOR;
      (opcode_i == OP_LEA):  mode_o = ALU_ADDSH2;
      default:               illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Multi-cycle execute controller driving the KGP-RISC ALU and register file.
// One instruction per four cycles: IDLE -> DECODE -> EXEC -> WB.
module alu_issue_ctrl
  import kgp_isa_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter bit R0_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  output logic [REG_AW-1:0] rf_raddr1,
  output logic [REG_AW-1:0] rf_raddr2,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2,
  output logic [DATA_W-1:0] alu_op1,
  output logic [DATA_W-1:0] alu_op2,
  output logic [3:0]        alu_mode,
  output logic              alu_en,
  input  logic [DATA_W-1:0] alu_out,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              zero_flag,
  output logic              sign_flag,
  output logic              illegal
);

  state_e st_q, st_d;

  logic [31:0]       instr_q;
  logic [DATA_W-1:0] op1_q, op2_q, res_q;
  logic [3:0]        mode_q;
  logic [REG_AW-1:0] dest_q;
  logic              zf_q, sf_q;

  logic [3:0]        dec_mode;
  logic [4:0]        dec_dest;
  logic              dec_use_imm;
  logic              dec_ill;
  logic [DATA_W-1:0] imm_sx;

  alu_ctrl_decode u_dec (
    .opcode_i  (instr_q[31:26]),
    .funct_i   (instr_q[3:0]),
    .rt_i      (instr_q[20:16]),
    .rd_i      (instr_q[15:11]),
    .mode_o    (dec_mode),
    .dest_o    (dec_dest),
    .use_imm_o (dec_use_imm),
    .illegal_o (dec_ill)
  );

  assign imm_sx = {{(DATA_W-16){instr_q[15]}}, instr_q[15:0]};

  always_ff @(posedge clk) begin
    if (rst) st_q <= IDLE;
    else     st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      IDLE:    if (in_valid) st_d = DECODE;
      DECODE:  st_d = dec_ill ? IDLE : EXEC;
      EXEC:    st_d = WB;
      WB:      st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  // Pulses are masked by rst so an aborted instruction leaves no trace.
  always_comb begin
    in_ready  = (st_q == IDLE);
    alu_en    = (st_q == EXEC);
    illegal   = (st_q == DECODE) && dec_ill && !rst;
    rf_we     = (st_q == WB) && !rst &&
                !(R0_ZERO && (dest_q == '0));
    rf_raddr1 = '0;
    rf_raddr2 = '0;
    if (st_q == DECODE) begin
      rf_raddr1 = REG_AW'(instr_q[25:21]);
      rf_raddr2 = REG_AW'(instr_q[20:16]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      mode_q  <= '0;
      dest_q  <= '0;
      res_q   <= '0;
      zf_q    <= 1'b0;
      sf_q    <= 1'b0;
    end else begin
      if (st_q == IDLE && in_valid)
        instr_q <= instr;
      if (st_q == DECODE && !dec_ill) begin
        op1_q  <= rf_rdata1;
        op2_q  <= dec_use_imm ? imm_sx : rf_rdata2;
        mode_q <= dec_mode;
        dest_q <= REG_AW'(dec_dest);
      end
      if (st_q == EXEC)
        res_q <= alu_out;
      if (st_q == WB) begin
        zf_q <= (res_q == '0);
        sf_q <= res_q[DATA_W-1];
      end
    end
  end

  assign alu_op1   = op1_q;
  assign alu_op2   = op2_q;
  assign alu_mode  = mode_q;
  assign rf_waddr  = dest_q;
  assign rf_wdata  = res_q;
  assign zero_flag = zf_q;
  assign sign_flag = sf_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl with a behavioural ALU and register file.
// Stimulus pushes expected outcomes; a negedge monitor pops and compares.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic [31:0] alu_op1, alu_op2;
  logic [3:0]  alu_mode;
  logic        alu_en;
  logic [31:0] alu_out;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        zero_flag, sign_flag, illegal;

  alu_issue_ctrl dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_mode(alu_mode),
    .alu_en(alu_en), .alu_out(alu_out),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .zero_flag(zero_flag), .sign_flag(sign_flag), .illegal(illegal)
  );

  always #5 clk = ~clk;

  logic [31:0] rf [32];
  assign rf_rdata1 = rf[rf_raddr1];
  assign rf_rdata2 = rf[rf_raddr2];

  // External ALU as seen by the controller; garbage when not enabled.
  function automatic logic [31:0] alu_f(logic [3:0] m, logic [31:0] a, logic [31:0] b);
    case (m)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return ~a;
      4'd6:  return a << b;
      4'd7:  return a >> b;
      4'd8:  return $unsigned($signed(a) >>> b);
      4'd9:  return a << b;
      4'd10: return a + (b << 2);
      default: return 32'h0;
    endcase
  endfunction
  assign alu_out = alu_en ? alu_f(alu_mode, alu_op1, alu_op2) : 32'hDEAD_BEEF;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  typedef struct {
    bit          ill;
    bit          we;
    logic [4:0]  addr;
    logic [31:0] data;
    bit          z;
    bit          s;
  } exp_t;
  exp_t sbq[$];

  bit mdl_z = 0, mdl_s = 0;

  // Instruction-level reference: what the architecture says each op writes.
  function automatic bit ref_exec(input logic [31:0] ins, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] r);
    logic [5:0]  op = ins[31:26];
    logic [3:0]  fn = ins[3:0];
    logic [31:0] sx = {{16{ins[15]}}, ins[15:0]};
    int unsigned sh = b;
    r = 32'h0;
    if (op == 6'h00) begin
      case (fn)
        4'd0: r = a + b;
        4'd1: r = a - b;
        4'd2: r = a & b;
        4'd3: r = a | b;
        4'd4: r = a ^ b;
        4'd5: r = ~a;
        4'd6, 4'd9: r = (sh > 31) ? 32'h0 : a * (32'd1 << sh);
        4'd7: r = (sh > 31) ? 32'h0 : a / (32'd1 << sh);
        4'd8: r = (sh > 31) ? {32{a[31]}} :
                  (a[31] ? ~((~a) / (32'd1 << sh)) : a / (32'd1 << sh));
        default: return 1'b0;
      endcase
      return 1'b1;
    end
    case (op)
      6'h01: r = a + sx;
      6'h02: r = a & sx;
      6'h03: r = a | sx;
      6'h04: r = a ^ sx;
      6'h05: r = a + sx * 4;
      default: return 1'b0;
    endcase
    return 1'b1;
  endfunction

  function automatic logic [31:0] mk_r(int rs, int rt, int rd, int fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 7'h0, 4'(fn)};
  endfunction

  function automatic logic [31:0] mk_i(int op, int rs, int rt, logic [15:0] imm);
    return {6'(op), 5'(rs), 5'(rt), imm};
  endfunction

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int acc_cyc;

  // Waits for IDLE, loads rs/rt, drives instr and returns just after the handshake.
  task automatic issue(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                       input bit hold, input bit exp_en);
    bit ok = 0;
    exp_t e;
    logic [31:0] r;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      if (in_ready) ok = 1;
    end
    if (!ok) begin
      n_chk++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 for instr %h", ins);
      return;
    end
    rf[ins[25:21]] = a;
    rf[ins[20:16]] = b;
    rf[0] = 32'h0;
    instr = ins;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    if (!hold) in_valid = 1'b0;
    if (exp_en) begin
      e.ill = !ref_exec(ins, rf[ins[25:21]], rf[ins[20:16]], r);
      e.we = 0; e.addr = 0; e.data = 0;
      if (!e.ill) begin
        e.addr = (ins[31:26] == 6'h00) ? ins[15:11] : ins[20:16];
        e.we = (e.addr != 0);
        e.data = r;
        mdl_z = (r == 0);
        mdl_s = r[31];
      end
      e.z = mdl_z;
      e.s = mdl_s;
      sbq.push_back(e);
    end
  endtask

  bit busy = 0;
  int mcyc = 0, st_cyc, we_cnt, we_off, ill_cnt, ill_off;
  logic [4:0]  got_addr;
  logic [31:0] got_data;

  always @(negedge clk) begin
    exp_t e;
    mcyc++;
    if (rst) begin
      busy = 0;
    end else begin
      if (busy) begin
        if (rf_we) begin
          we_cnt++; we_off = mcyc - st_cyc;
          got_addr = rf_waddr; got_data = rf_wdata;
        end
        if (illegal) begin
          ill_cnt++; ill_off = mcyc - st_cyc;
        end
        if (in_ready) begin
          busy = 0;
          if (sbq.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_txn: got completion expected none");
          end else begin
            e = sbq.pop_front();
            chk("illegal_cnt", ill_cnt, e.ill ? 1 : 0);
            if (e.ill) chk("illegal_offset", ill_off, 1);
            chk("busy_len", mcyc - st_cyc, e.ill ? 2 : 4);
            chk("we_cnt", we_cnt, e.we ? 1 : 0);
            if (e.we) begin
              chk("we_offset", we_off, 3);
              chk("waddr", got_addr, e.addr);
              chk("wdata", got_data, e.data);
            end
            chk("zero_flag", zero_flag, e.z);
            chk("sign_flag", sign_flag, e.s);
          end
        end
      end
      if (in_valid && in_ready) begin
        busy = 1; st_cyc = mcyc;
        we_cnt = 0; we_off = 0; ill_cnt = 0; ill_off = 0;
        got_addr = 0; got_data = 0;
      end
    end
  end

  initial begin
    int a0, wes;
    logic [31:0] ins, va, vb;
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    rst = 1'b1; in_valid = 1'b0; instr = 32'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_pulses", {alu_en, rf_we, illegal, zero_flag, sign_flag}, 0);
    chk("rst_op1", alu_op1, 0);
    chk("rst_op2", alu_op2, 0);
    chk("rst_mode_addr", {alu_mode, rf_waddr, rf_raddr1, rf_raddr2}, 0);
    chk("rst_wdata", rf_wdata, 0);

    issue(mk_r(1, 2, 3, 0), 5, 7, 0, 1);
    issue(mk_r(1, 2, 5, 1), 32'h8000_0000, 32'h8000_0000, 0, 1);
    issue(mk_r(8, 9, 10, 1), 0, 1, 0, 1);
    issue(mk_i(1, 0, 4, 16'hFFFF), 0, 0, 0, 1);
    issue(mk_i(5, 6, 7, 16'h0004), 32'h1000, 0, 0, 1);
    issue(mk_i(6'h3F, 1, 2, 16'h0), 1, 2, 0, 1);
    issue(mk_r(1, 2, 3, 4'hB), 1, 2, 0, 1);
    issue(mk_r(11, 12, 13, 6), 32'h0000_0001, 32'd40, 0, 1);
    issue(mk_r(11, 12, 13, 8), 32'h8000_0000, 32'd33, 0, 1);
    issue(mk_r(1, 2, 0, 1), 0, 1, 0, 1);
    issue(mk_r(1, 2, 0, 0), 3, 32'hFFFF_FFFD, 0, 1);

    issue(mk_r(14, 15, 16, 0), 10, 20, 1, 1);
    a0 = acc_cyc;
    issue(mk_r(17, 18, 19, 2), 32'hF0F0, 32'hFF00, 1, 1);
    chk("b2b_gap1", acc_cyc - a0, 4);
    a0 = acc_cyc;
    issue(mk_i(4, 20, 21, 16'h8001), 32'h1234_5678, 0, 1, 1);
    chk("b2b_gap2", acc_cyc - a0, 4);
    in_valid = 1'b0;

    for (int n = 0; n < 150; n++) begin
      int sel = $urandom_range(0, 9);
      int op;
      if (sel < 4) op = 0;
      else if (sel < 9) op = sel - 3;
      else op = $urandom_range(6, 63);
      va = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      vb = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 40) : $urandom;
      if (op == 0)
        ins = mk_r($urandom_range(0, 31), $urandom_range(0, 31),
                   $urandom_range(0, 31), $urandom_range(0, 15));
      else
        ins = mk_i(op, $urandom_range(0, 31), $urandom_range(0, 31), 16'($urandom));
      issue(ins, va, vb, $urandom_range(0, 1), 1);
    end
    in_valid = 1'b0;

    for (int k = 0; k < 50 && (sbq.size() != 0 || busy); k++) @(negedge clk);
    chk("drain_left", sbq.size(), 0);

    issue(mk_r(1, 2, 3, 0), 100, 200, 0, 0);
    @(posedge clk);
    #1;
    chk("abort_in_exec", alu_en, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_ready", in_ready, 1);
    chk("abort_we", rf_we, 0);
    rst = 1'b0;
    wes = 0;
    repeat (6) begin
      @(negedge clk);
      if (rf_we) wes++;
    end
    chk("abort_no_we", wes, 0);

    issue(mk_i(6'h3F, 1, 2, 16'h0), 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    chk("abort_no_illegal", illegal, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort2_ready", in_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
